// File: rtl/seq_divider16_if.sv
// Request/result handshake bundle for the sequential divider.
// The requester drives the master side; the divider implements the slave side.
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial
// subtraction built from 4-bit carry-lookahead blocks.
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  seq_divider16_if.slave  bus
);
  localparam int NBLK = WIDTH / 4;
  localparam int CW   = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             dbz_reg;

  // Trial subtraction S - D as S + ~{0,D} + 1. The partial remainder stays
  // below D, so only S carries the extra top bit; the restored value fits WIDTH.
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] t;
  logic [3:0]       gg;
  logic [3:0]       pp;
  logic             cin;
  logic             blk_g;
  logic             no_borrow;

  // NOTE: every always_comb output gets a default before any conditional or
  // loop assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    s     = {r_reg, q_reg[WIDTH-1]};
    b     = ~d_reg;
    g     = s[WIDTH-1:0] & b;
    p     = s[WIDTH-1:0] ^ b;
    c     = '0;
    c[0]  = 1'b1;
    gg    = '0;
    pp    = '0;
    cin   = 1'b0;
    blk_g = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      cin  = c[4*k];
      gg   = g[4*k +: 4];
      pp   = p[4*k +: 4];
      c[4*k+1] = gg[0] | (pp[0] & cin);
      c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
      c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & cin);
      blk_g    = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]);
      c[4*k+4] = blk_g | ((&pp) & cin);
    end
    t = p ^ c[WIDTH-1:0];
    // Top bit of ~{0,D} is 1, so the final carry is S[WIDTH] | c[WIDTH].
    no_borrow = s[WIDTH] | c[WIDTH];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      cnt           <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_ready_reg) begin
            in_ready_reg <= 1'b1;
          end else if (bus.in_valid) begin
            in_ready_reg <= 1'b0;
            if (bus.x2 == '0) begin
              state   <= DONE;
              q_reg   <= '1;
              r_reg   <= bus.x1;
              dbz_reg <= 1'b1;
            end else begin
              state   <= RUN;
              q_reg   <= bus.x1;
              d_reg   <= bus.x2;
              r_reg   <= '0;
              cnt     <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          if (no_borrow) begin
            r_reg <= t;
            q_reg <= {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            r_reg <= s[WIDTH-1:0];
            q_reg <= {q_reg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          // Zero-divisor results arrive here with out_valid low; raise it one edge later.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider16.sv
// Scoreboard bench for seq_divider16: directed corner cases, then randomized
// traffic checked against a plain-arithmetic reference model.
module tb_seq_divider16;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic clk;
  logic rst;
  logic rand_on;
  int   n_tests;
  int   n_fail;
  res_t exp_q[$];

  seq_divider16_if #(.WIDTH(W)) bus ();

  seq_divider16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] d);
    res_t e;
    if (d == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / d;
      e.r   = a % d;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic abort(input string nm);
    n_fail++;
    $display("FAIL %s: bound expired", nm);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "aborted");
  endtask

  // Monitor: every handoff pops exactly one expected result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb_q",   {16'b0, bus.q}, {16'b0, e.q});
        check("sb_r",   {16'b0, bus.r}, {16'b0, e.r});
        check("sb_dbz", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      bus.out_ready = ($urandom % 4) != 0;
    end
  end

  // Presents a request from posedge+1 and returns at posedge+1 after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.x1 = a;
    bus.x2 = d;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      if (n > 200) abort("accept_wait");
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    exp_q.push_back(ref_div(a, d));
    #1;
    bus.in_valid = 1'b0;
    bus.x1 = W'($urandom);
    bus.x2 = W'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid is seen; returns on that negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
      if (lat > 100) abort("result_wait");
    end
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ed, input int elat, input string nm);
    int lat;
    issue(a, d);
    wait_result(lat);
    check({nm, "_lat"}, lat, elat);
    check({nm, "_q"},   {16'b0, bus.q}, {16'b0, eq});
    check({nm, "_r"},   {16'b0, bus.r}, {16'b0, er});
    check({nm, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, ed});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    abort("watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] hold_q, hold_r;
    n_tests = 0;
    n_fail  = 0;
    rand_on = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x1 = '0;
    bus.x2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_q",   {16'b0, bus.q}, 32'd0);
    check("rst_r",   {16'b0, bus.r}, 32'd0);
    check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    @(posedge clk);
    #1;

    directed(16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 16, "basic");
    directed(16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 16, "div1");
    directed(16'hFFFF,  16'h8000,   16'd1,      16'h7FFF,   1'b0, 16, "div8000");
    directed(16'd5,     16'd9,      16'd0,      16'd5,      1'b0, 16, "small");
    directed(16'hFFFE,  16'hFFFF,   16'd0,      16'hFFFE,   1'b0, 16, "maxdiv");
    directed(16'h1234,  16'd0,      16'hFFFF,   16'h1234,   1'b1, 1,  "zero");

    // Backpressure: result held, new requests ignored, then handoff timing.
    bus.out_ready = 1'b0;
    issue(16'd1000, 16'd7);
    wait_result(lat);
    hold_q = bus.q;
    hold_r = bus.r;
    bus.in_valid = 1'b1;
    bus.x1 = 16'd77;
    bus.x2 = 16'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_q",         {16'b0, bus.q}, {16'b0, hold_q});
      check("bp_r",         {16'b0, bus.r}, {16'b0, hold_r});
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_in_ready",  {31'b0, bus.in_ready}, 32'd0);
    end
    check("bp_value_q", {16'b0, hold_q}, 32'd142);
    check("bp_value_r", {16'b0, hold_r}, 32'd6);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ho_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("ho_in_ready0", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("ho_in_ready1", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    directed(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 16, "after_bp");

    // Reset eight clocks into RUN discards the in-flight operation.
    issue(16'hBEEF, 16'h0123);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    check("mid_rst_q", {16'b0, bus.q}, 32'd0);
    check("mid_rst_r", {16'b0, bus.r}, 32'd0);
    repeat (20) @(negedge clk);
    check("mid_rst_no_stale", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    directed(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 16, "after_rst");

    // Random regression with random request gaps and result backpressure.
    rand_on = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      logic [W-1:0] a, d;
      int gap;
      a = W'($urandom);
      case ($urandom % 8)
        0:       d = '0;
        1:       d = 16'd1;
        2:       d = W'($urandom_range(1, 15));
        3:       d = 16'h8000 | W'($urandom);
        default: d = W'($urandom);
      endcase
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      issue(a, d);
    end
    rand_on = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int n = 0; exp_q.size() != 0; n++) begin
      if (n > 200) abort("drain");
      @(posedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
